// File: rtl/bc_pkg.sv
// bc_pkg: shared definitions for the Basic Computer character input device.
//   BC_CHAR_W         default character width (INPR width)
//   bc_inport_state_t input-port handshake state
//   bc_level_w()      width of a FIFO occupancy count for a given depth
package bc_pkg;

    localparam int BC_CHAR_W = 8;

    typedef enum logic {
        IDLE,
        READY
    } bc_inport_state_t;

    // Occupancy runs 0..depth inclusive, so one extra bit over the address width.
    function automatic int bc_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bc_input_port_if.sv
// bc_input_port_if: device/controller-facing signals of the input port.
//   dev_stb, dev_data  keystroke strobe and character from the device
//   inp_ack            INP acknowledge from the controller
//   ovf_clr            clears the sticky overrun flag
//   FGI, INPR          input flag and input register toward the CPU
//   level, ovf         FIFO occupancy (excluding INPR) and sticky overrun
// Modports: master drives stimulus/acks and observes status; slave is the port.
interface bc_input_port_if
    import bc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = BC_CHAR_W
) ();

    localparam int LW = bc_level_w(DEPTH);

    logic          dev_stb;
    logic [DW-1:0] dev_data;
    logic          inp_ack;
    logic          ovf_clr;
    logic          FGI;
    logic [DW-1:0] INPR;
    logic [LW-1:0] level;
    logic          ovf;

    modport master (
        output dev_stb, dev_data, inp_ack, ovf_clr,
        input  FGI, INPR, level, ovf
    );

    modport slave (
        input  dev_stb, dev_data, inp_ack, ovf_clr,
        output FGI, INPR, level, ovf
    );

endinterface

// File: rtl/bc_sync_fifo.sv
// bc_sync_fifo: single-clock FIFO with registered occupancy count.
//   clk, rst_n   clock, asynchronous active-low reset (pointers/level to 0)
//   push, push_data  write request; honoured when not full or when popping
//   pop          read request; honoured when not empty
//   full, empty  status decoded from level
//   level        occupancy 0..DEPTH
//   head_data    combinational read of the head entry
module bc_sync_fifo
    import bc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = BC_CHAR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [bc_level_w(DEPTH)-1:0] level,
    output logic [DW-1:0]                head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = bc_level_w(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full      = (count == LW'(DEPTH));
    assign empty     = (count == '0);
    assign level     = count;
    assign head_data = mem[rd_ptr];

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bc_input_port.sv
// bc_input_port: Basic Computer character input device (FGI/INPR handshake).
// Buffers device strobes in a FIFO, presents one character on INPR with FGI
// raised, and drops FGI when the controller acknowledges with inp_ack.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         bc_input_port_if.slave (dev_stb, dev_data, inp_ack, ovf_clr,
//               FGI, INPR, level, ovf)
// Build option: define BC_INPORT_OVF_EN to enable the sticky overrun flag;
// otherwise ovf reads 0 and dropped characters are silent.
module bc_input_port
    import bc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = BC_CHAR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bc_input_port_if.slave         bus
);

    localparam int LW = bc_level_w(DEPTH);

    bc_inport_state_t state_q;
    bc_inport_state_t state_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [DW-1:0] fifo_head;
    logic          pop;
    logic          accept;
    logic          drop;
    logic [DW-1:0] inpr_q;
    logic          fgi;

    // Only IDLE loads INPR, which guarantees a one-cycle FGI gap between characters.
    assign pop    = (state_q == IDLE) && !fifo_empty;
    assign accept = bus.dev_stb && (!fifo_full || pop);
    assign drop   = bus.dev_stb && !accept;

    bc_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (bus.dev_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .head_data (fifo_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty)  state_d = READY;
            READY:   if (bus.inp_ack)  state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin
        fgi = 1'b0;
        if (state_q == READY) fgi = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   inpr_q <= '0;
        else if (pop) inpr_q <= fifo_head;
    end

    assign bus.FGI   = fgi;
    assign bus.INPR  = inpr_q;
    assign bus.level = fifo_level;

`ifdef BC_INPORT_OVF_EN
    logic ovf_q;

    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           ovf_q <= 1'b0;
        else if (drop)        ovf_q <= 1'b1;
        else if (bus.ovf_clr) ovf_q <= 1'b0;
    end

    assign bus.ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = drop | bus.ovf_clr;
    assign bus.ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_bc_input_port.sv
module tb_bc_input_port;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

`ifdef BC_INPORT_OVF_EN
    localparam logic OVF_E = 1'b1;
`else
    localparam logic OVF_E = 1'b0;
`endif

    typedef struct {
        logic       stb;
        logic [7:0] data;
        logic       ack;
        logic       clr;
        logic       fgi;
        logic [7:0] inpr;
        logic [2:0] level;
        logic       ovf;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    bc_input_port_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

    bc_input_port #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic fgi, input logic [7:0] inpr,
                             input logic [2:0] level, input logic ovf);
        check({tag, " FGI"},   32'(bus.FGI),   32'(fgi));
        check({tag, " INPR"},  32'(bus.INPR),  32'(inpr));
        check({tag, " level"}, 32'(bus.level), 32'(level));
        check({tag, " ovf"},   32'(bus.ovf),   32'(ovf));
    endtask

    task automatic add(input logic stb, input logic [7:0] data, input logic ack, input logic clr,
                       input logic fgi, input logic [7:0] inpr, input logic [2:0] level, input logic ovf);
        vec_t v;
        v.stb = stb; v.data = data; v.ack = ack; v.clr = clr;
        v.fgi = fgi; v.inpr = inpr; v.level = level; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic stb, input logic [7:0] data, input logic ack, input logic clr);
        bus.dev_stb  = stb;
        bus.dev_data = data;
        bus.inp_ack  = ack;
        bus.ovf_clr  = clr;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        //   stb  data   ack   clr   | FGI  INPR   lvl  ovf
        add(1'b1, 8'h41, 1'b0, 1'b0,   1'b0, 8'h00, 3'd1, 1'b0); // strobe into empty FIFO
        add(1'b0, 8'h00, 1'b0, 1'b0,   1'b1, 8'h41, 3'd0, 1'b0); // loaded one edge later
        add(1'b0, 8'h00, 1'b1, 1'b0,   1'b0, 8'h41, 3'd0, 1'b0); // ack drops FGI, INPR held
        add(1'b0, 8'h00, 1'b1, 1'b0,   1'b0, 8'h41, 3'd0, 1'b0); // ack in IDLE ignored
        add(1'b0, 8'h00, 1'b0, 1'b0,   1'b0, 8'h41, 3'd0, 1'b0);
        add(1'b1, 8'h30, 1'b0, 1'b0,   1'b0, 8'h41, 3'd1, 1'b0); // six back-to-back strobes
        add(1'b1, 8'h31, 1'b0, 1'b0,   1'b1, 8'h30, 3'd1, 1'b0); // pop 0x30 + push 0x31
        add(1'b1, 8'h32, 1'b0, 1'b0,   1'b1, 8'h30, 3'd2, 1'b0);
        add(1'b1, 8'h33, 1'b0, 1'b0,   1'b1, 8'h30, 3'd3, 1'b0);
        add(1'b1, 8'h34, 1'b0, 1'b0,   1'b1, 8'h30, 3'd4, 1'b0); // full
        add(1'b1, 8'h35, 1'b0, 1'b0,   1'b1, 8'h30, 3'd4, OVF_E); // 0x35 dropped
        add(1'b1, 8'h36, 1'b0, 1'b1,   1'b1, 8'h30, 3'd4, OVF_E); // drop + clear: set wins
        add(1'b0, 8'h00, 1'b0, 1'b1,   1'b1, 8'h30, 3'd4, 1'b0);  // clear alone
        add(1'b0, 8'h00, 1'b1, 1'b0,   1'b0, 8'h30, 3'd4, 1'b0);  // ack while full
        add(1'b1, 8'h5A, 1'b0, 1'b0,   1'b1, 8'h31, 3'd4, 1'b0);  // pop+push at full
        add(1'b0, 8'h00, 1'b1, 1'b0,   1'b0, 8'h31, 3'd4, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0,   1'b1, 8'h32, 3'd3, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0,   1'b0, 8'h32, 3'd3, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0,   1'b1, 8'h33, 3'd2, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0,   1'b0, 8'h33, 3'd2, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0,   1'b1, 8'h34, 3'd1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0,   1'b0, 8'h34, 3'd1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0,   1'b1, 8'h5A, 3'd0, 1'b0);  // wrapped slot
        add(1'b0, 8'h00, 1'b1, 1'b0,   1'b0, 8'h5A, 3'd0, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0,   1'b0, 8'h5A, 3'd0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].stb, vecs[i].data, vecs[i].ack, vecs[i].clr);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].fgi, vecs[i].inpr, vecs[i].level, vecs[i].ovf);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Reach READY with level=2, then reset between edges
        drive(1'b1, 8'h10, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 8'h12, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_all("pre_rst", 1'b1, 8'h10, 3'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Post-reset strobe behaves like the first transaction
        drive(1'b1, 8'h41, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        check_all("post_rst_k", 1'b0, 8'h00, 3'd1, 1'b0);
        @(posedge clk); #1;
        check_all("post_rst_k1", 1'b1, 8'h41, 3'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
